// File: rtl/ascii_seg_scanner_if.sv
// Display bus between the digit-register side and the segment scanner.
// The master drives the digit bytes and the change flag; the scanner drives the 7-segment outputs.
interface ascii_seg_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  logic [8*NUM_DIGITS-1:0] digits_in;
  logic                    flag_in;
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_done;

  modport master (
    output digits_in,
    output flag_in,
    input  seg,
    input  an,
    input  frame_done
  );

  modport slave (
    input  digits_in,
    input  flag_in,
    output seg,
    output an,
    output frame_done
  );
endinterface

// File: rtl/ascii_seg_scanner.sv
// Time-multiplexed ASCII to 7-segment scanner with tear-free snapshots.
// Staged data is committed to the shadow register only at a frame boundary.
module ascii_seg_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 8,
  parameter int BLANK_CYC  = 2
) (
  input  logic                clk,
  input  logic                reset,
  ascii_seg_scanner_if.slave  bus
);

  localparam int MAXC = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int TW   = $clog2(MAXC + 1);
  localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW   = 8 * NUM_DIGITS;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [DW-1:0]   stage_q, stage_d;
  logic [DW-1:0]   shadow_q, shadow_d;
  logic            pending_q, pending_d;
  logic [6:0]      seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic            fd_q, fd_d;
  logic            last_dig;

  function automatic logic [6:0] decode(input logic [7:0] c);
    logic [6:0] s;
    case (c)
      8'h30:   s = 7'h7E;
      8'h31:   s = 7'h30;
      8'h32:   s = 7'h6D;
      8'h33:   s = 7'h79;
      8'h34:   s = 7'h33;
      8'h35:   s = 7'h5B;
      8'h36:   s = 7'h5F;
      8'h37:   s = 7'h70;
      8'h38:   s = 7'h7F;
      8'h39:   s = 7'h7B;
      8'h2D:   s = 7'h01;
      8'h41:   s = 7'h77;
      8'h50:   s = 7'h67;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  assign last_dig = (idx_q == IW'(NUM_DIGITS - 1));

  // Next-state: scan sequencing, snapshot capture/commit, output precompute
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    timer_d   = timer_q;
    stage_d   = stage_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    seg_d     = 7'h00;
    an_d      = '0;
    fd_d      = 1'b0;

    unique case (state_q)
      BLANK: begin
        if (timer_q == TW'(BLANK_CYC - 1)) begin
          state_d = DRIVE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      DRIVE: begin
        if (timer_q == TW'(SCAN_DIV - 1)) begin
          state_d = BLANK;
          timer_d = '0;
          idx_d   = last_dig ? '0 : idx_q + IW'(1);
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: ;
    endcase

    // fd_q marks the last cycle of the frame, so this edge is the boundary
    if (fd_q && pending_q) begin
      shadow_d  = stage_q;
      pending_d = 1'b0;
    end
    if (bus.flag_in) begin
      stage_d   = bus.digits_in;
      pending_d = 1'b1;
    end

    if (state_d == DRIVE) begin
      an_d  = NUM_DIGITS'(1) << idx_d;
      seg_d = decode(shadow_d[{idx_d, 3'b000} +: 8]);
      fd_d  = (idx_d == IW'(NUM_DIGITS - 1)) &&
              (timer_d == TW'(SCAN_DIV - 1));
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= BLANK;
      idx_q     <= '0;
      timer_q   <= '0;
      stage_q   <= '1;
      shadow_q  <= '1;
      pending_q <= 1'b0;
      seg_q     <= 7'h00;
      an_q      <= '0;
      fd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      timer_q   <= timer_d;
      stage_q   <= stage_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
      fd_q      <= fd_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.frame_done = fd_q;

endmodule
